// File: rtl/dec_pkg.sv
// dec_pkg: shared types, default sizes and the decode function for dec_pipe.
// The decode function is written once at the largest legal code width
// (10 bits, 1024 outputs). Callers truncate the result to their own OUT_W.
package dec_pkg;

    localparam int DEC_IN_W_DEF   = 8;
    localparam int DEC_CNT_W_DEF  = 16;
    localparam int DEC_CODE_W_MAX = 10;
    localparam int DEC_OUT_W_MAX  = 1 << DEC_CODE_W_MAX;

    typedef enum logic [1:0] {
        DEC_ONEHOT = 2'd0,
        DEC_THERM  = 2'd1,
        DEC_INV    = 2'd2,
        DEC_RSVD   = 2'd3
    } dec_mode_e;

    // Thermometer is derived from the one-hot word: (onehot << 1) - 1 sets every
    // bit at or below the code. At the top code the shift wraps to zero, and the
    // subtraction then gives all ones, which is still correct.
    function automatic logic [DEC_OUT_W_MAX-1:0] dec_decode(
        input logic [DEC_CODE_W_MAX-1:0] code,
        input dec_mode_e                 mode
    );
        logic [DEC_OUT_W_MAX-1:0] one_hot;
        logic [DEC_OUT_W_MAX-1:0] bits;
        one_hot       = '0;
        one_hot[code] = 1'b1;
        case (mode)
            DEC_ONEHOT: bits = one_hot;
            DEC_THERM:  bits = (one_hot << 1) - DEC_OUT_W_MAX'(1);
            DEC_INV:    bits = ~one_hot;
            default:    bits = '0;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/dec_pipe_skid.sv
// dec_pipe_skid: output register plus a one-entry skid buffer for dec_pipe.
// This module is used only when DEC_PIPE_SKID_EN is defined.
// The skid entry holds the raw code and mode rather than the decoded word.
// It is decoded only when it moves into the output register, so the wide
// decoded word is never stored twice.
// in_ready is driven only by the skid-occupancy register, gated by rst.
// It has no path from out_ready.
module dec_pipe_skid
    import dec_pkg::*;
#(
    parameter int  IN_W  = DEC_IN_W_DEF,
    localparam int OUT_W = 2 ** IN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_code,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_bits,
    output logic              out_err
);

    logic            skid_valid;
    logic [IN_W-1:0] skid_code;
    dec_mode_e       skid_mode;
    logic            accept;
    logic            drain;

    assign in_ready = ~skid_valid & ~rst;
    assign accept   = in_valid & in_ready;
    assign drain    = ~out_valid | out_ready;

    // Refill the output register from the skid entry first (it is older). Otherwise
    // take the new input. Park the new input in the skid entry when the output stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_bits   <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_code  <= '0;
            skid_mode  <= DEC_ONEHOT;
        end else if (drain) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_bits   <= OUT_W'(dec_decode(DEC_CODE_W_MAX'(skid_code), skid_mode));
                out_err    <= (skid_mode == DEC_RSVD);
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_bits <= OUT_W'(dec_decode(DEC_CODE_W_MAX'(in_code), dec_mode_e'(in_mode)));
                    out_err  <= (dec_mode_e'(in_mode) == DEC_RSVD);
                end
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_code  <= in_code;
            skid_mode  <= dec_mode_e'(in_mode);
        end
    end

endmodule

// File: rtl/dec_pipe.sv
// dec_pipe: registered code decoder with a valid/ready handshake on both sides
// and a saturating count of output transfers.
// Build option DEC_PIPE_SKID_EN: when defined, a one-entry skid buffer makes in_ready
// a registered signal. When it is undefined, in_ready is combinational from out_ready
// and there is a single result register.
// Both builds produce the same output sequence.
module dec_pipe
    import dec_pkg::*;
#(
    parameter int  IN_W  = DEC_IN_W_DEF,
    parameter int  CNT_W = DEC_CNT_W_DEF,
    localparam int OUT_W = 2 ** IN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_code,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_bits,
    output logic              out_err,
    output logic [CNT_W-1:0]  xfer_cnt
);

`ifdef DEC_PIPE_SKID_EN

    dec_pipe_skid #(
        .IN_W (IN_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_err   (out_err)
    );

`else

    assign in_ready = ~rst & (~out_valid | out_ready);

    // Single result register: it loads whenever the current result is gone or
    // leaving this cycle, which gives one transfer per cycle with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_bits  <= '0;
            out_err   <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_bits <= OUT_W'(dec_decode(DEC_CODE_W_MAX'(in_code), dec_mode_e'(in_mode)));
                out_err  <= (dec_mode_e'(in_mode) == DEC_RSVD);
            end
        end
    end

`endif

    // Count completed output transfers, holding at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready && (xfer_cnt != {CNT_W{1'b1}})) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dec_pipe.sv
// tb_dec_pipe: scoreboard bench for dec_pipe (IN_W=8, CNT_W=4).
// Expected results are queued when an input transfer is seen and popped when
// an output transfer is seen. Works with or without DEC_PIPE_SKID_EN.
module tb_dec_pipe;

    localparam int IN_W  = 8;
    localparam int CNT_W = 4;
    localparam int OUT_W = 256;
`ifdef DEC_PIPE_SKID_EN
    localparam int EXP_ACC = 2;
`else
    localparam int EXP_ACC = 1;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_bits;
    logic             out_err;
    logic [CNT_W-1:0] xfer_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [OUT_W:0] sb[$];

    dec_pipe #(
        .IN_W  (IN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_err   (out_err),
        .xfer_cnt  (xfer_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure throughput.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference decode: bit-by-bit, straight from the mode definitions.
    function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] code, input logic [1:0] mode);
        logic [OUT_W-1:0] b;
        b = '0;
        for (int k = 0; k < OUT_W; k++) begin
            case (mode)
                2'd0:    b[k] = (k == int'(code));
                2'd1:    b[k] = (k <= int'(code));
                2'd2:    b[k] = (k != int'(code));
                default: b[k] = 1'b0;
            endcase
        end
        return {(mode == 2'd3), b};
    endfunction

    // Scoreboard: on output transfers, pop the oldest expected result and compare.
    // On input transfers, push the expected result. Reset discards everything held.
    always @(negedge clk) begin
        logic [OUT_W:0] exp_v;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    $display("[TB] FAIL sb_extra: got err=%b bits=%h, required no output", out_err, out_bits);
                    n_err++;
                end else begin
                    exp_v = sb.pop_front();
                    if ({out_err, out_bits} !== exp_v) begin
                        $display("[TB] FAIL sb_data: got err=%b bits=%h, required err=%b bits=%h",
                                 out_err, out_bits, exp_v[OUT_W], exp_v[OUT_W-1:0]);
                        n_err++;
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_code, in_mode));
        end
    end

    // Watchdog so a hung design cannot stall the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [IN_W-1:0] code, input logic [1:0] mode);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_code  = code;
        in_mode  = mode;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_code   = 8'h11;
        in_mode   = 2'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({out_valid, out_err, in_ready} !== 3'b000 || out_bits !== '0 || xfer_cnt !== '0) begin
            $display("[TB] FAIL reset_state: got valid=%b err=%b ready=%b cnt=%0d bits=%h, required all zero",
                     out_valid, out_err, in_ready, xfer_cnt, out_bits);
            n_err++;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("[TB] FAIL reset_release: got ready=%b valid=%b, required ready=1 valid=0", in_ready, out_valid);
            n_err++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_onehot();
        logic [OUT_W-1:0] e;
        e         = '0;
        e[5]      = 1'b1;
        out_ready = 1'b1;
        applyStimulus(8'h05, 2'd0);
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || out_bits !== e || out_err !== 1'b0) begin
            $display("[TB] FAIL onehot5: got valid=%b err=%b bits=%h, required valid=1 err=0 bits=%h",
                     out_valid, out_err, out_bits, e);
            n_err++;
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (xfer_cnt !== 4'd1 || out_valid !== 1'b0) begin
            $display("[TB] FAIL onehot_cnt: got cnt=%0d valid=%b, required cnt=1 valid=0", xfer_cnt, out_valid);
            n_err++;
        end
    endtask

    task automatic test_modes();
        logic [IN_W-1:0] codes [7] = '{8'h03, 8'hFF, 8'h00, 8'h42, 8'h07, 8'h80, 8'hA5};
        logic [1:0]      modes [7] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd2};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) applyStimulus(codes[i], modes[i]);
        in_valid = 1'b0;
        settle(3);
        // Garbage on code/mode with in_valid low must not produce output.
        in_code = 8'hEE;
        in_mode = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                $display("[TB] FAIL ignore_invalid: got valid=%b, required 0", out_valid);
                n_err++;
            end
        end
        n_vec++;
        if (sb.size() != 0) begin
            $display("[TB] FAIL modes_drain: got %0d pending, required 0", sb.size());
            n_err++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        int               accepts;
        logic             acc;
        logic             have_ref;
        logic [OUT_W-1:0] ref_bits;
        logic             ref_err;
        do_reset();
        accepts   = 0;
        have_ref  = 1'b0;
        ref_bits  = '0;
        ref_err   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 8'h10;
        in_mode   = 2'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (!have_ref) begin
                    ref_bits = out_bits;
                    ref_err  = out_err;
                    have_ref = 1'b1;
                end else begin
                    n_vec++;
                    if (out_bits !== ref_bits || out_err !== ref_err) begin
                        $display("[TB] FAIL stall_stable: got err=%b bits=%h, required err=%b bits=%h",
                                 out_err, out_bits, ref_err, ref_bits);
                        n_err++;
                    end
                end
            end
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                accepts++;
                in_code = in_code + 8'h01;
                in_mode = 2'(accepts % 3);
            end
        end
        n_vec++;
        if (accepts != EXP_ACC || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            $display("[TB] FAIL stall_accepts: got %0d accepts ready=%b valid=%b, required %0d ready=0 valid=1",
                     accepts, in_ready, out_valid, EXP_ACC);
            n_err++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        settle(5);
        n_vec++;
        if (sb.size() != 0 || int'(xfer_cnt) != accepts) begin
            $display("[TB] FAIL stall_drain: got %0d pending cnt=%0d, required 0 pending cnt=%0d",
                     sb.size(), xfer_cnt, accepts);
            n_err++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_code   = 8'($urandom_range(0, 255));
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        settle(5);
        n_vec++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            $display("[TB] FAIL random_drain: got %0d pending valid=%b, required 0 pending valid=0",
                     sb.size(), out_valid);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        int start;
        int span;
        do_reset();
        out_ready = 1'b1;
        start     = cyc;
        for (int i = 0; i < 20; i++) applyStimulus(8'(i * 7), 2'(i % 4));
        span     = cyc - start;
        in_valid = 1'b0;
        n_vec++;
        if (span != 20) begin
            $display("[TB] FAIL b2b_rate: got %0d cycles for 20 inputs, required 20", span);
            n_err++;
        end
        settle(3);
        n_vec++;
        if (xfer_cnt !== 4'd15 || sb.size() != 0) begin
            $display("[TB] FAIL b2b_sat: got cnt=%0d pending=%0d, required cnt=15 pending=0", xfer_cnt, sb.size());
            n_err++;
        end
        applyStimulus(8'h01, 2'd0);
        in_valid = 1'b0;
        settle(3);
        n_vec++;
        if (xfer_cnt !== 4'd15) begin
            $display("[TB] FAIL b2b_hold: got cnt=%0d, required 15", xfer_cnt);
            n_err++;
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 8'h33;
        in_mode   = 2'd0;
        settle(1);
        in_code = 8'h34;
        settle(1);
        in_valid = 1'b0;
        settle(1);
        rst = 1'b1;
        settle(1);
        n_vec++;
        if (out_valid !== 1'b0 || xfer_cnt !== 4'd0 || in_ready !== 1'b0) begin
            $display("[TB] FAIL midrst: got valid=%b cnt=%0d ready=%b, required valid=0 cnt=0 ready=0",
                     out_valid, xfer_cnt, in_ready);
            n_err++;
        end
        out_ready = 1'b1;
        rst       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0 || (i == 0 && in_ready !== 1'b1)) begin
                $display("[TB] FAIL midrst_stale: got valid=%b ready=%b at cycle %0d, required valid=0 ready=1",
                         out_valid, in_ready, i);
                n_err++;
            end
        end
        @(posedge clk);
        #1;
        applyStimulus(8'h21, 2'd1);
        in_valid = 1'b0;
        settle(3);
        n_vec++;
        if (sb.size() != 0 || xfer_cnt !== 4'd1) begin
            $display("[TB] FAIL midrst_after: got pending=%0d cnt=%0d, required pending=0 cnt=1", sb.size(), xfer_cnt);
            n_err++;
        end
    endtask

    // Test sequence.
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        test_reset();
        test_onehot();
        test_modes();
        test_stall();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
